// File: rtl/sirene_alarme_if.sv
// Alarm-response bus: request/acknowledge toward the controller, siren and
// indicator flags plus the trigger count back out.
interface sirene_alarme_if #(
    parameter int LARGURA_CONT = 8
) ();
    logic                    alarme;
    logic                    reconhecer;
    logic                    sirene;
    logic                    disparado;
    logic                    aguardando;
    logic [LARGURA_CONT-1:0] ocorrencias;

    modport master (
        output alarme,
        output reconhecer,
        input  sirene,
        input  disparado,
        input  aguardando,
        input  ocorrencias
    );

    modport slave (
        input  alarme,
        input  reconhecer,
        output sirene,
        output disparado,
        output aguardando,
        output ocorrencias
    );
endinterface

// File: rtl/sirene_alarme.sv
// Alarm-response controller: debounces the alarm request, latches a trigger,
// pulses the siren for a bounded time and honours operator acknowledge.
module sirene_alarme #(
    parameter int FILTRO       = 4,
    parameter int MEIO_PERIODO = 8,
    parameter int DURACAO      = 64,
    parameter int LARGURA_CONT = 8
) (
    input  logic           clk,
    input  logic           rst,
    sirene_alarme_if.slave bus
);
    localparam int FW = $clog2(FILTRO);
    localparam int PW = (MEIO_PERIODO > 1) ? $clog2(MEIO_PERIODO) : 1;
    localparam int DW = $clog2(DURACAO + 1);

    localparam logic [FW-1:0] FILTRO_ULT = FW'(FILTRO - 1);
    localparam logic [PW-1:0] FASE_ULT   = PW'(MEIO_PERIODO - 1);
    localparam logic [DW-1:0] DUR_ULT    = DW'(DURACAO - 1);

    typedef enum logic [1:0] {
        REPOUSO   = 2'd0,
        FILTRANDO = 2'd1,
        DISPARADO = 2'd2,
        SILENCIO  = 2'd3
    } estado_t;

    estado_t                 estado, estado_n;
    logic [FW-1:0]           filt, filt_n;
    logic [PW-1:0]           fase, fase_n;
    logic [DW-1:0]           dur, dur_n;
    logic [LARGURA_CONT-1:0] cont, cont_n;
    logic                    sirene_q, sirene_n;
    logic                    disp_q, agu_q;

    function automatic logic [LARGURA_CONT-1:0] inc_sat(input logic [LARGURA_CONT-1:0] v);
        return (&v) ? v : v + LARGURA_CONT'(1);
    endfunction

    always_comb begin
        estado_n = estado;
        filt_n   = filt;
        fase_n   = fase;
        dur_n    = dur;
        cont_n   = cont;
        sirene_n = 1'b0;
        case (estado)
            REPOUSO: begin
                if (bus.alarme) begin
                    estado_n = FILTRANDO;
                    filt_n   = FW'(1);
                end
            end
            FILTRANDO: begin
                if (!bus.alarme) begin
                    estado_n = REPOUSO;
                    filt_n   = '0;
                end else if (filt == FILTRO_ULT) begin
                    estado_n = DISPARADO;
                    filt_n   = '0;
                    fase_n   = '0;
                    dur_n    = '0;
                    cont_n   = inc_sat(cont);
                    sirene_n = 1'b1;
                end else begin
                    filt_n = filt + FW'(1);
                end
            end
            DISPARADO: begin
                // Acknowledge wins over a timeout landing in the same cycle.
                if (bus.reconhecer) begin
                    estado_n = bus.alarme ? SILENCIO : REPOUSO;
                end else if (dur == DUR_ULT) begin
                    estado_n = SILENCIO;
                end else begin
                    dur_n = dur + DW'(1);
                    if (fase == FASE_ULT) begin
                        fase_n   = '0;
                        sirene_n = ~sirene_q;
                    end else begin
                        fase_n   = fase + PW'(1);
                        sirene_n = sirene_q;
                    end
                end
            end
            SILENCIO: begin
                if (!bus.alarme) estado_n = REPOUSO;
            end
            default: estado_n = REPOUSO;
        endcase
    end

    // Flags are registered from the next state so they track the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= REPOUSO;
            filt     <= '0;
            fase     <= '0;
            dur      <= '0;
            cont     <= '0;
            sirene_q <= 1'b0;
            disp_q   <= 1'b0;
            agu_q    <= 1'b0;
        end else begin
            estado   <= estado_n;
            filt     <= filt_n;
            fase     <= fase_n;
            dur      <= dur_n;
            cont     <= cont_n;
            sirene_q <= sirene_n;
            disp_q   <= (estado_n == DISPARADO);
            agu_q    <= (estado_n == SILENCIO);
        end
    end

    assign bus.sirene      = sirene_q;
    assign bus.disparado   = disp_q;
    assign bus.aguardando  = agu_q;
    assign bus.ocorrencias = cont;
endmodule

// File: tb/tb_sirene_alarme.sv
// Directed bench for sirene_alarme: default instance plus a narrow-counter,
// short-duration instance for the saturation scenario.
module tb_sirene_alarme;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_oc = 0;

    always #5 clk = ~clk;

    sirene_alarme_if #(.LARGURA_CONT(8)) b0 ();
    sirene_alarme_if #(.LARGURA_CONT(2)) b1 ();

    sirene_alarme #(.FILTRO(4), .MEIO_PERIODO(8), .DURACAO(64), .LARGURA_CONT(8)) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );
    sirene_alarme #(.FILTRO(4), .MEIO_PERIODO(8), .DURACAO(4), .LARGURA_CONT(2)) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    wire [2:0] f0 = {b0.disparado, b0.aguardando, b0.sirene};
    wire [2:0] f1 = {b1.disparado, b1.aguardando, b1.sirene};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        b0.alarme = 0; b0.reconhecer = 0;
        b1.alarme = 0; b1.reconhecer = 0;
        #2;
        checks++;
        if (f0 !== 3'b000) begin errors++; $display("FAIL reset_flags0 got %b exp %b", f0, 3'b000); end
        checks++;
        if (b0.ocorrencias !== 8'd0) begin errors++; $display("FAIL reset_oc0 got %0d exp 0", b0.ocorrencias); end
        checks++;
        if (f1 !== 3'b000) begin errors++; $display("FAIL reset_flags1 got %b exp %b", f1, 3'b000); end
        @(negedge clk);
        rst = 0;
        step();
        checks++;
        if (f0 !== 3'b000) begin errors++; $display("FAIL reset_idle got %b exp %b", f0, 3'b000); end
    endtask

    task automatic test_glitch();
        b0.alarme = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b0.disparado !== 1'b0) begin errors++; $display("FAIL glitch_hold%0d got %b exp 0", i, b0.disparado); end
        end
        b0.alarme = 0;
        step();
        checks++;
        if (f0 !== 3'b000) begin errors++; $display("FAIL glitch_drop got %b exp %b", f0, 3'b000); end
        checks++;
        if (b0.ocorrencias !== 8'd0) begin errors++; $display("FAIL glitch_oc got %0d exp 0", b0.ocorrencias); end
        // Filter restart: two highs, one low, then four fresh highs needed.
        b0.alarme = 1;
        step(); step();
        b0.alarme = 0;
        step();
        b0.alarme = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b0.disparado !== 1'b0) begin errors++; $display("FAIL restart_hold%0d got %b exp 0", i, b0.disparado); end
        end
        step();
        exp_oc++;
        checks++;
        if (f0 !== 3'b101) begin errors++; $display("FAIL restart_trig got %b exp %b", f0, 3'b101); end
        checks++;
        if (b0.ocorrencias !== 8'(exp_oc)) begin errors++; $display("FAIL restart_oc got %0d exp %0d", b0.ocorrencias, exp_oc); end
        b0.alarme = 0; b0.reconhecer = 1;
        step();
        b0.reconhecer = 0;
        checks++;
        if (f0 !== 3'b000) begin errors++; $display("FAIL restart_ack got %b exp %b", f0, 3'b000); end
    endtask

    task automatic test_trigger_timeout();
        logic es;
        int   bad;
        b0.alarme = 1;
        repeat (4) step();
        exp_oc++;
        checks++;
        if (b0.ocorrencias !== 8'(exp_oc)) begin errors++; $display("FAIL trig_oc got %0d exp %0d", b0.ocorrencias, exp_oc); end
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            es = ((k / 8) % 2) == 0;
            checks++;
            if (f0 !== {1'b1, 1'b0, es}) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL siren_k%0d got %b exp %b", k, f0, {1'b1, 1'b0, es});
            end
            step();
        end
        checks++;
        if (f0 !== 3'b010) begin errors++; $display("FAIL timeout got %b exp %b", f0, 3'b010); end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (f0 !== 3'b010) begin errors++; $display("FAIL no_retrig%0d got %b exp %b", i, f0, 3'b010); end
        end
        b0.alarme = 0;
        step();
        checks++;
        if (f0 !== 3'b000) begin errors++; $display("FAIL rearm got %b exp %b", f0, 3'b000); end
    endtask

    task automatic test_latch();
        b0.alarme = 1;
        repeat (4) step();
        exp_oc++;
        b0.alarme = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (b0.disparado !== 1'b1) begin errors++; $display("FAIL latch%0d got %b exp 1", i, b0.disparado); end
        end
        b0.reconhecer = 1;
        step();
        b0.reconhecer = 0;
        checks++;
        if (f0 !== 3'b000) begin errors++; $display("FAIL latch_ack got %b exp %b", f0, 3'b000); end
        checks++;
        if (b0.ocorrencias !== 8'(exp_oc)) begin errors++; $display("FAIL latch_oc got %0d exp %0d", b0.ocorrencias, exp_oc); end
    endtask

    task automatic test_ack();
        // Acknowledge with the request low returns to idle.
        b0.alarme = 1;
        repeat (4) step();
        exp_oc++;
        repeat (19) step();
        b0.alarme = 0; b0.reconhecer = 1;
        step();
        b0.reconhecer = 0;
        checks++;
        if (f0 !== 3'b000) begin errors++; $display("FAIL ack_low got %b exp %b", f0, 3'b000); end
        // Acknowledge with the request still high parks in the silence state.
        b0.alarme = 1;
        repeat (4) step();
        exp_oc++;
        repeat (19) step();
        b0.reconhecer = 1;
        step();
        b0.reconhecer = 0;
        checks++;
        if (f0 !== 3'b010) begin errors++; $display("FAIL ack_high got %b exp %b", f0, 3'b010); end
        b0.alarme = 0;
        step();
        checks++;
        if (f0 !== 3'b000) begin errors++; $display("FAIL ack_high_clear got %b exp %b", f0, 3'b000); end
        // Acknowledge coincident with the last cycle beats the timeout.
        b0.alarme = 1;
        repeat (4) step();
        exp_oc++;
        repeat (63) step();
        checks++;
        if (b0.disparado !== 1'b1) begin errors++; $display("FAIL ack_last_pre got %b exp 1", b0.disparado); end
        b0.alarme = 0; b0.reconhecer = 1;
        step();
        b0.reconhecer = 0;
        checks++;
        if (f0 !== 3'b000) begin errors++; $display("FAIL ack_vs_timeout got %b exp %b", f0, 3'b000); end
        checks++;
        if (b0.ocorrencias !== 8'(exp_oc)) begin errors++; $display("FAIL ack_oc got %0d exp %0d", b0.ocorrencias, exp_oc); end
    endtask

    task automatic test_reset_mid();
        b0.alarme = 1;
        repeat (4) step();
        step(); step();
        checks++;
        if (f0 !== 3'b101) begin errors++; $display("FAIL mid_pre got %b exp %b", f0, 3'b101); end
        #3 rst = 1;
        #1;
        checks++;
        if (f0 !== 3'b000) begin errors++; $display("FAIL mid_async got %b exp %b", f0, 3'b000); end
        checks++;
        if (b0.ocorrencias !== 8'd0) begin errors++; $display("FAIL mid_oc got %0d exp 0", b0.ocorrencias); end
        #2 rst = 0;
        exp_oc = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (b0.disparado !== 1'b0) begin errors++; $display("FAIL mid_refilt%0d got %b exp 0", i, b0.disparado); end
        end
        step();
        exp_oc++;
        checks++;
        if (f0 !== 3'b101) begin errors++; $display("FAIL mid_retrig got %b exp %b", f0, 3'b101); end
        checks++;
        if (b0.ocorrencias !== 8'(exp_oc)) begin errors++; $display("FAIL mid_retrig_oc got %0d exp %0d", b0.ocorrencias, exp_oc); end
        b0.alarme = 0; b0.reconhecer = 1;
        step();
        b0.reconhecer = 0;
    endtask

    task automatic test_saturation();
        logic [1:0] tab [5];
        tab[0] = 2'd1; tab[1] = 2'd2; tab[2] = 2'd3; tab[3] = 2'd3; tab[4] = 2'd3;
        for (int n = 0; n < 5; n++) begin
            b1.alarme = 1;
            repeat (4) step();
            checks++;
            if (b1.ocorrencias !== tab[n] || b1.disparado !== 1'b1) begin
                errors++; $display("FAIL sat%0d got oc=%0d d=%b exp oc=%0d d=1", n, b1.ocorrencias, b1.disparado, tab[n]);
            end
            repeat (4) step();
            checks++;
            if (f1 !== 3'b010) begin errors++; $display("FAIL sat_to%0d got %b exp %b", n, f1, 3'b010); end
            b1.alarme = 0;
            step();
            checks++;
            if (f1 !== 3'b000) begin errors++; $display("FAIL sat_clr%0d got %b exp %b", n, f1, 3'b000); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_glitch();
        test_trigger_timeout();
        test_latch();
        test_ack();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sirene_alarme.md
# sirene_alarme

Alarm-response controller at the receiving end of the alarm request line (Y = janela | (porta & sistema)). It debounces the incoming request, latches a trigger, drives a pulsed siren for a bounded time, and accepts an operator acknowledge. It also keeps a saturating count of triggers. It sits between the combinational alarm logic and the siren/indicator outputs.

## Interface
- FILTRO, 4: consecutive high samples of `alarme` required to trigger; legal range ≥ 2.
- MEIO_PERIODO, 8: siren half-period in cycles; ≥ 1.
- DURACAO, 64: maximum cycles spent in DISPARADO before auto-silence; ≥ 1.
- LARGURA_CONT, 8: width of the trigger counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- alarme  input  1  alarm request from the alarm logic, synchronous to clk.
- reconhecer  input  1  operator acknowledge; level sampled each cycle.
- sirene  output  1  pulsed siren drive, registered.
- disparado  output  1  high while in DISPARADO, registered.
- aguardando  output  1  high while in SILENCIO (waiting for request to clear), registered.
- ocorrencias  output  LARGURA_CONT  number of triggers since reset, saturating, registered.

## Operation
- States: REPOUSO, FILTRANDO, DISPARADO, SILENCIO.
- REPOUSO:
  - `alarme`=1 → FILTRANDO, filter count = 1.
  - Otherwise stay.
- FILTRANDO:
  - `alarme`=0 → REPOUSO, filter count cleared.
  - `alarme`=1 with count = FILTRO-1 → DISPARADO.
  - Otherwise count+1.
  - `reconhecer` is ignored.
- DISPARADO:
  - On entry: `ocorrencias` += 1, saturating at 2^LARGURA_CONT−1; siren phase and duration timers cleared.
  - `sirene`=1 for the first MEIO_PERIODO cycles, then 0 for MEIO_PERIODO cycles, repeating.
  - The trigger is latched: `alarme` falling does not leave DISPARADO.
  - `reconhecer`=1 → REPOUSO if `alarme`=0 in the same cycle, otherwise SILENCIO.
  - Duration timer reaches DURACAO cycles in the state → SILENCIO.
  - `reconhecer` takes priority over timeout in the same cycle.
- SILENCIO:
  - `sirene`=0, `aguardando`=1.
  - `alarme`=0 → REPOUSO.
  - `reconhecer` is ignored.
  - A new trigger requires `alarme` to go low and then pass the filter again.
- Output decode:
  - `disparado` = (state==DISPARADO).
  - `aguardando` = (state==SILENCIO).
  - `sirene` is 0 in every state other than DISPARADO.
- Counter widths:
  - Filter counter: ceil(log2(FILTRO)) bits.
  - Siren phase counter: ceil(log2(MEIO_PERIODO)) bits.
  - Duration counter: ceil(log2(DURACAO+1)) bits.
  - No counter wraps.

## Timing
- Reset (async, any state):
  - State = REPOUSO.
  - sirene=0, disparado=0, aguardando=0, ocorrencias=0.
  - All internal counters = 0.
  - Outputs change immediately on rst assertion, without waiting for a clock edge.
  - First state change is possible at the first rising edge after rst deasserts.
- Trigger latency: with `alarme` high on edges 1…FILTRO, `disparado`=1, `sirene`=1 and the new `ocorrencias` value are all visible immediately after edge FILTRO.
- Filter restart: a low sample at any edge before FILTRO returns to REPOUSO; the count restarts from zero.
- Timeout: without acknowledge, `disparado` is high for exactly DURACAO cycles, then `aguardando` rises on the following edge.
- Siren output: the last siren phase may be truncated by the timeout.
- Acknowledge latency: `reconhecer` sampled high at edge N in DISPARADO → `disparado`=0 and `sirene`=0 after edge N.
- Back-to-back triggers: a trigger from SILENCIO requires at least 1 cycle in REPOUSO plus FILTRO cycles.

## Test plan
- Glitch rejection (defaults): `alarme` high 3 cycles then low → state stays REPOUSO/FILTRANDO; disparado stays 0; ocorrencias=0.
- Trigger and siren pattern: `alarme` high 4 cycles → disparado=1 after 4th edge, ocorrencias=1, sirene pattern 8 cycles 1, 8 cycles 0, repeating. `alarme` then dropped → still DISPARADO.
- Timeout and rearm: no acknowledge, `alarme` held high → disparado high exactly 64 cycles, then aguardando=1, sirene=0. Hold `alarme` high 10 more cycles → no retrigger. Drop it → REPOUSO next cycle.
- Acknowledge paths:
  - reconhecer=1 at cycle 20 of DISPARADO with `alarme`=0 → REPOUSO, all flags 0.
  - Repeated with `alarme`=1 → SILENCIO, aguardando=1.
  - reconhecer coincident with the 64th cycle → acknowledge path taken.
- Reset mid-operation: assert rst between clock edges during DISPARADO with sirene=1 → sirene, disparado and ocorrencias go 0 immediately. Deassert → REPOUSO, and a new trigger needs 4 fresh high samples.
- Saturation (LARGURA_CONT=2, DURACAO=4): five full trigger/timeout/clear sequences → ocorrencias reads 1, 2, 3, 3, 3.
